// File: rtl/alu_func.sv
// Registered 13-bit unsigned ALU: eight operations with a one-bit
// exception flag, one result per cycle, one cycle of latency.
module alu_func (
  input  logic        aclk,
  input  logic        areset,
  input  logic [12:0] x,
  input  logic [12:0] y,
  input  logic [2:0]  opcode,
  output logic [12:0] result,
  output logic        status
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHL = 3'd7
  } op_e;

  op_e         op;
  logic [13:0] sum;
  logic [13:0] dif;
  logic [25:0] prod;
  logic [27:0] shl;
  logic [12:0] quo;
  logic [12:0] result_d, result_q;
  logic        status_d, status_q;

  assign op = op_e'(opcode);

  // Wide intermediates expose carry, borrow and overflow bits
  always_comb begin
    sum  = {1'b0, x} + {1'b0, y};
    dif  = {1'b0, x} - {1'b0, y};
    prod = {13'b0, x} * {13'b0, y};
    shl  = {15'b0, x} << y[3:0];
    quo  = (y == 13'd0) ? 13'h1FFF : x / y;
  end

  // Select the operation result and its exception flag
  always_comb begin
    result_d = '0;
    status_d = 1'b0;
    unique case (op)
      OP_ADD: begin
        result_d = sum[12:0];
        status_d = sum[13];
      end
      OP_SUB: begin
        result_d = dif[12:0];
        status_d = dif[13];
      end
      OP_MUL: begin
        result_d = prod[12:0];
        status_d = |prod[25:13];
      end
      OP_DIV: begin
        result_d = quo;
        status_d = (y == 13'd0);
      end
      OP_AND: result_d = x & y;
      OP_OR:  result_d = x | y;
      OP_XOR: result_d = x ^ y;
      OP_SHL: begin
        result_d = shl[12:0];
        status_d = |shl[27:13];
      end
    endcase
  end

  // Output register; reset wins over the sampled operation
  always_ff @(posedge aclk) begin
    if (areset) begin
      result_q <= '0;
      status_q <= 1'b0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_func.sv
// Bench for alu_func: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_func;

  logic        aclk = 1'b0;
  logic        areset;
  logic [12:0] x;
  logic [12:0] y;
  logic [2:0]  opcode;
  logic [12:0] result;
  logic        status;

  int n_pass = 0;
  int n_total = 0;

  int er;
  bit es;
  bit en = 1'b0;

  alu_func dut (
    .aclk   (aclk),
    .areset (areset),
    .x      (x),
    .y      (y),
    .opcode (opcode),
    .result (result),
    .status (status)
  );

  always #5 aclk = ~aclk;

  // Reference behaviour from plain integer arithmetic
  function automatic void model(input int a, input int b, input int op,
                                output int r, output bit s);
    longint p;
    r = 0;
    s = 1'b0;
    case (op)
      0: begin p = a + b; r = int'(p % 8192); s = (p > 8191); end
      1: begin r = (a - b + 8192) % 8192; s = (b > a); end
      2: begin
        p = longint'(a) * longint'(b);
        r = int'(p % 8192);
        s = (p > 8191);
      end
      3: begin
        if (b == 0) begin r = 8191; s = 1'b1; end
        else r = a / b;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin
        p = longint'(a) * (longint'(1) << (b % 16));
        r = int'(p % 8192);
        s = (p > 8191);
      end
    endcase
  endfunction

  task automatic check(input string name, input int ar, input bit as_,
                       input int xr, input bit xs);
    n_total++;
    if (ar != xr || as_ != xs)
      $display("FAIL %s: got result=%0h status=%0b, want result=%0h status=%0b",
               name, ar, as_, xr, xs);
    else
      n_pass++;
  endtask

  // Model-based compare, one check per cycle once reset has been seen
  initial begin
    forever begin
      @(posedge aclk);
      if (areset) begin
        er = 0;
        es = 1'b0;
        en = 1'b1;
      end else if (en) begin
        model(int'(x), int'(y), int'(opcode), er, es);
      end
      #1;
      if (en) check("model", int'(result), status, er, es);
    end
  end

  task automatic apply(input string name, input bit r, input int op,
                       input int a, input int b, input int xr, input bit xs);
    @(negedge aclk);
    areset = r;
    opcode = 3'(op);
    x = 13'(a);
    y = 13'(b);
    @(posedge aclk);
    #2;
    check(name, int'(result), status, xr, xs);
  endtask

  initial begin
    areset = 1'b1;
    x = 13'd4;
    y = 13'd2;
    opcode = 3'd0;

    apply("reset0", 1, 0, 4, 2, 0, 0);
    apply("reset1", 1, 0, 4, 2, 0, 0);
    apply("post_reset", 0, 0, 4, 2, 6, 0);

    apply("sw_add", 0, 0, 4, 2, 6, 0);
    apply("sw_sub", 0, 1, 4, 2, 2, 0);
    apply("sw_mul", 0, 2, 4, 2, 8, 0);
    apply("sw_div", 0, 3, 4, 2, 2, 0);
    apply("sw_and", 0, 4, 4, 2, 0, 0);
    apply("sw_or",  0, 5, 4, 2, 6, 0);
    apply("sw_xor", 0, 6, 4, 2, 6, 0);
    apply("sw_shl", 0, 7, 4, 2, 16, 0);

    apply("add_ovf", 0, 0, 'h1FFF, 1, 0, 1);
    apply("sub_brw", 0, 1, 2, 4, 'h1FFE, 1);
    apply("mul_ovf", 0, 2, 'h100, 'h40, 0, 1);
    apply("div_zero", 0, 3, 100, 0, 'h1FFF, 1);
    apply("div_7", 0, 3, 100, 7, 14, 0);
    apply("shl_12", 0, 7, 1, 12, 'h1000, 0);
    apply("shl_12_out", 0, 7, 3, 12, 'h1000, 1);
    apply("shl_y16", 0, 7, 1, 'h10, 1, 0);
    apply("shl_15", 0, 7, 1, 15, 0, 1);

    apply("mid_rst", 1, 2, 50, 50, 0, 0);
    apply("mid_rel", 0, 2, 50, 50, 'd2500, 0);

    apply("hold_pre", 0, 0, 4, 2, 6, 0);
    @(negedge aclk);
    opcode = 3'd2;
    #1;
    check("hold_mid", int'(result), status, 6, 0);
    @(posedge aclk);
    #2;
    check("hold_next", int'(result), status, 8, 0);

    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      areset = ($urandom_range(0, 49) == 0);
      opcode = 3'($urandom_range(0, 7));
      x = 13'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(0, 16))
                                      : 13'($urandom);
    end

    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_func.md
# alu_func

Registered 13-bit unsigned arithmetic/logic unit. Each rising edge of `aclk` it samples `x`, `y` and `opcode`, computes one of eight operations, and registers the 13-bit result with a one-bit status flag. It is a leaf datapath block used as a single-cycle execute stage; there is no handshake, and a new operation may be issued every cycle.

## Interface
- Parameters: none. Data width is fixed at 13 bits, opcode width at 3 bits.
- `aclk` input 1: clock; all state updates on the rising edge.
- `areset` input 1: synchronous, active-high reset, sampled on the rising edge of `aclk`.
- `x` input 13: operand A, unsigned.
- `y` input 13: operand B, unsigned.
- `opcode` input 3: operation select.
- `result` output 13: registered operation result.
- `status` output 1: registered exception flag (overflow / out-of-range / divide-by-zero).

## Operation
- All operands are treated as unsigned 13-bit values. `result` is the low 13 bits of the true result unless stated otherwise.
- opcode 0, ADD: `result = x + y`. `status` = carry out of bit 12.
- opcode 1, SUB: `result = x - y` (two's-complement wrap). `status` = 1 when y > x (borrow).
- opcode 2, MUL: `result` = low 13 bits of x*y (full product is 26 bits). `status` = 1 when any of product bits 25..13 is nonzero.
- opcode 3, DIV: `result = floor(x / y)`. `status = 0` when y ≠ 0. When y = 0: `result = 13'h1FFF` and `status = 1`.
- opcode 4, AND: `result = x & y`. `status = 0`.
- opcode 5, OR: `result = x | y`. `status = 0`.
- opcode 6, XOR: `result = x ^ y`. `status = 0`.
- opcode 7, SHL: `result = x << y[3:0]`, zero fill. y[12:4] are ignored, so a shift of 13 to 15 gives 0.
  - `status` = 1 when any 1 bit is shifted out past bit 12.
- Every one of the 8 opcode values is defined, so there is no illegal-opcode case.
- Division is purely combinational. No multi-cycle divider and no stall.

## Timing
- Latency is 1 cycle. Inputs are sampled at rising edge N, and `result`/`status` reflect them immediately after edge N.
- Outputs hold their value between edges. Input changes between edges have no effect on the outputs until the next edge.
- Throughput is one operation per cycle. Back-to-back opcode changes on consecutive cycles each produce their own result on consecutive cycles.
- Reset: if `areset` = 1 at a rising edge, then `result` = 0 and `status` = 0 after that edge, regardless of the inputs.
  - Reset takes priority over the computation.
  - The first edge with `areset` = 0 produces a normal result.
- Reset asserted mid-stream discards the operation sampled on that edge. There is no other internal state.
- Before the first reset or the first clock edge, the outputs are don't-care. The bench must not check them.

## Test plan
- Reset: drive `areset` = 1 for 2 edges with x=4, y=2, opcode=0 -> `result` = 0 and `status` = 0. Release reset -> the next edge gives `result` = 6.
- Opcode sweep: x=4, y=2, opcode stepped 0 through 7, one step per cycle -> `result` = 6, 2, 8, 2, 0, 6, 6, 16 on consecutive cycles, with `status` = 0 for all.
- Overflow flags:
  - ADD with x=0x1FFF, y=1 -> `result` = 0, `status` = 1.
  - SUB with x=2, y=4 -> `result` = 0x1FFE, `status` = 1.
  - MUL with x=0x100, y=0x40 -> `result` = 0, `status` = 1.
- Divide by zero: DIV with x=100, y=0 -> `result` = 0x1FFF, `status` = 1. DIV with x=100, y=7 -> `result` = 14, `status` = 0.
- Shift boundaries:
  - SHL with x=1, y=12 -> `result` = 0x1000, `status` = 0.
  - SHL with x=3, y=12 -> `result` = 0x1000, `status` = 1.
  - SHL with x=1, y=0x10 -> `result` = 1 (only y[3:0] = 0 is used), `status` = 0.
- Input change between edges: change `opcode` half a cycle after an edge -> the outputs stay unchanged until the next rising edge, then reflect the new opcode.
